// File: rtl/mux8_1_serializer.sv
// Parallel-to-serial front end: loads an 8-bit word and walks {S2,S1,S0} over it, one bit per accepted beat.
// Optional feature: define PARITY_EN to append an even-parity beat after the eight data beats.
`timescale 1ns/1ps

module mux8_1_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] din,
  output logic [2:0] sel,
  output logic       ser_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       last,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam logic [2:0] SEL_START = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] SEL_TERM  = LSB_FIRST ? 3'd7 : 3'd0;

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_q;
  logic [2:0]          sel_q, sel_d;
  logic                load;
  logic                at_term;

  assign load    = in_valid && (state_q == IDLE);
  assign at_term = (sel_q == SEL_TERM);
  assign sel     = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (load) word_q <= din;
    end
  end

  // Outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    ser_out   = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = SHIFT;
          sel_d   = SEL_START;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = word_q[sel_q];
        last      = at_term;
        if (out_ready) begin
          if (at_term) begin
`ifdef PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            sel_d   = 3'd0;
`endif
          end else if (LSB_FIRST) begin
            sel_d = sel_q + 3'd1;
          end else begin
            sel_d = sel_q - 3'd1;
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        // sel stays on the terminal value while the parity bit is presented
        out_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = ^word_q;
        last      = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          sel_d   = 3'd0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux8_1_serializer.sv
// Scoreboard bench for mux8_1_serializer: one LSB-first and one MSB-first instance share clock, reset and data.
`timescale 1ns/1ps

module tb_mux8_1_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_l, in_valid_m;
  logic       in_ready_l, in_ready_m;
  logic [7:0] din;
  logic [2:0] sel_l, sel_m;
  logic       ser_l, ser_m;
  logic       out_valid_l, out_valid_m;
  logic       out_ready;
  logic       last_l, last_m;
  logic       busy_l, busy_m;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4:0] q_l[$];
  logic [4:0] q_m[$];

  always #5 clk = ~clk;

  mux8_1_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l), .din(din),
    .sel(sel_l), .ser_out(ser_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .last(last_l), .busy(busy_l)
  );

  mux8_1_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m), .din(din),
    .sel(sel_m), .ser_out(ser_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .last(last_m), .busy(busy_m)
  );

  // Monitor: every accepted beat is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_l && out_ready) begin
        n_cmp++;
        if (q_l.size() == 0) begin
          n_fail++;
          $display("FAIL lsb_beat unexpected: got sel=%0d ser=%0b last=%0b, none required", sel_l, ser_l, last_l);
        end else begin
          logic [4:0] e;
          e = q_l.pop_front();
          if ({sel_l, ser_l, last_l} !== e) begin
            n_fail++;
            $display("FAIL lsb_beat: got sel=%0d ser=%0b last=%0b, want sel=%0d ser=%0b last=%0b",
                     sel_l, ser_l, last_l, e[4:2], e[1], e[0]);
          end
        end
      end
      if (out_valid_m && out_ready) begin
        n_cmp++;
        if (q_m.size() == 0) begin
          n_fail++;
          $display("FAIL msb_beat unexpected: got sel=%0d ser=%0b last=%0b, none required", sel_m, ser_m, last_m);
        end else begin
          logic [4:0] e;
          e = q_m.pop_front();
          if ({sel_m, ser_m, last_m} !== e) begin
            n_fail++;
            $display("FAIL msb_beat: got sel=%0d ser=%0b last=%0b, want sel=%0d ser=%0b last=%0b",
                     sel_m, ser_m, last_m, e[4:2], e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // seq lists the hand-computed serial bits in transmission order, left to right.
  task automatic push_word(input bit msb, input logic [0:7] seq, input logic par);
    for (int k = 0; k < 8; k++) begin
      logic [4:0] e;
      logic [2:0] s;
      s = msb ? 3'(7 - k) : 3'(k);
      e = {s, seq[k], (k == 7)};
      if (msb) q_m.push_back(e);
      else     q_l.push_back(e);
    end
`ifdef PARITY_EN
    if (msb) q_m.push_back({3'd0, par, 1'b1});
    else     q_l.push_back({3'd7, par, 1'b1});
`else
    if (par === 1'bx) $display("note: parity bit unspecified");
`endif
  endtask

  task automatic load(input bit msb, input logic [7:0] d);
    @(posedge clk); #1;
    din = d;
    if (msb) in_valid_m = 1'b1;
    else     in_valid_l = 1'b1;
    @(posedge clk); #1;
    in_valid_l = 1'b0;
    in_valid_m = 1'b0;
    din = 8'h5A;
    @(negedge clk); #1;
    if (msb) begin
      chk1("msb_load_out_valid", out_valid_m, 1'b1);
      chk1("msb_load_in_ready", in_ready_m, 1'b0);
    end else begin
      chk1("lsb_load_out_valid", out_valid_l, 1'b1);
      chk1("lsb_load_in_ready", in_ready_l, 1'b0);
      chk1("lsb_load_busy", busy_l, 1'b1);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q_l.size() != 0 || q_m.size() != 0) && i < 100) begin
      @(negedge clk); #1;
      i++;
    end
    n_cmp++;
    if (q_l.size() != 0 || q_m.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d beats pending, want 0/0", q_l.size(), q_m.size());
      q_l.delete();
      q_m.delete();
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk); #1;
    chk1({tag, "_in_ready_l"}, in_ready_l, 1'b1);
    chk1({tag, "_out_valid_l"}, out_valid_l, 1'b0);
    chk3({tag, "_sel_l"}, sel_l, 3'd0);
    chk1({tag, "_ser_l"}, ser_l, 1'b0);
    chk1({tag, "_in_ready_m"}, in_ready_m, 1'b1);
    chk3({tag, "_sel_m"}, sel_m, 3'd0);
  endtask

  task automatic wait_sel_l(input logic [2:0] s);
    int i;
    i = 0;
    while (sel_l != s && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk3("wait_sel_l", sel_l, s);
  endtask

  initial begin
    rst = 1'b1; in_valid_l = 1'b0; in_valid_m = 1'b0; din = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk1("rst_in_ready", in_ready_l, 1'b1);
    chk1("rst_out_valid", out_valid_l, 1'b0);
    chk3("rst_sel", sel_l, 3'd0);
    chk1("rst_ser_out", ser_l, 1'b0);
    chk1("rst_last", last_l, 1'b0);
    chk1("rst_busy", busy_l, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LSB-first stream of 8'b1101_0000
    push_word(1'b0, 8'b0000_1011, 1'b1);
    load(1'b0, 8'hD0);
    drain();
    idle_check("d0_idle");

    // Backpressure at sel=3 on 8'hA5
    push_word(1'b0, 8'b1010_0101, 1'b0);
    load(1'b0, 8'hA5);
    wait_sel_l(3'd3);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk3("stall_sel", sel_l, 3'd3);
      chk1("stall_ser", ser_l, 1'b0);
      chk1("stall_valid", out_valid_l, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    idle_check("a5_idle");

    // MSB-first stream of 8'h01
    push_word(1'b1, 8'b0000_0001, 1'b1);
    load(1'b1, 8'h01);
    drain();
    idle_check("msb_idle");

    // Reset in the middle of 8'hFF, then a clean 8'h00
    push_word(1'b0, 8'b1111_1111, 1'b0);
    load(1'b0, 8'hFF);
    wait_sel_l(3'd4);
    rst = 1'b1;
    #1;
    chk1("midrst_out_valid", out_valid_l, 1'b0);
    chk3("midrst_sel", sel_l, 3'd0);
    chk1("midrst_in_ready", in_ready_l, 1'b1);
    chk1("midrst_busy", busy_l, 1'b0);
    q_l.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_word(1'b0, 8'b0000_0000, 1'b0);
    load(1'b0, 8'h00);
    drain();
    idle_check("zero_idle");

    // Parity vectors (parity beat only exists with PARITY_EN)
    push_word(1'b0, 8'b1110_0000, 1'b1);
    load(1'b0, 8'h07);
    drain();
    push_word(1'b0, 8'b1100_0000, 1'b0);
    load(1'b0, 8'h03);
    drain();
    idle_check("par_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
